// File: rtl/int_sum_ctrl.sv
// int_sum_ctrl: sequencer for the CDP/LRN local-window sum-of-squares datapath.
// Turns a valid/ready stream of squared samples into the stage-1/stage-2 load
// strobes of the two-stage sum block, tracks pipeline occupancy, applies
// downstream backpressure, counts elements and pulses done after the last sum.
// Optional build macro INT_SUM_CTRL_PERF_EN adds a saturating stall counter
// (dp2reg_stall_cnt) counting cycles where a sum is held by the consumer.
module int_sum_ctrl #(
   parameter int CNT_W  = 16,
   parameter int PERF_W = 32
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             reg2dp_op_en,
   input  logic [1:0]       reg2dp_normalz_len,
   input  logic [CNT_W-1:0] reg2dp_elem_num,
   input  logic             sq_in_vld,
   output logic             sq_in_rdy,
   output logic             sum_out_vld,
   input  logic             sum_out_rdy,
   output logic             load_din_d,
   output logic             load_din_2d,
   output logic             len5,
   output logic             len7,
   output logic             len9,
   output logic [1:0]       len_sel,
   output logic             op_busy,
   output logic             dp2reg_done
`ifdef INT_SUM_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0] dp2reg_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             p1_vld;
   logic             p2_vld;
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] out_cnt;
   logic             out_hs;
   logic             last_in;
   logic             last_out;
   logic             start;

   // Next-state and pipeline strobes, all derived from registered state.
   always_comb begin
      next_state  = state;
      load_din_2d = p1_vld & (~p2_vld | sum_out_rdy);
      sq_in_rdy   = 1'b0;
      load_din_d  = 1'b0;
      sum_out_vld = p2_vld;
      op_busy     = (state != IDLE);
      out_hs      = p2_vld & sum_out_rdy;
      start       = 1'b0;
      last_in     = 1'b0;
      last_out    = 1'b0;
      case (state)
         IDLE: begin
            if (reg2dp_op_en) begin
               start      = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            sq_in_rdy  = ~p1_vld | load_din_2d;
            load_din_d = sq_in_vld & sq_in_rdy;
            last_in    = load_din_d & (in_cnt == reg2dp_elem_num);
            if (last_in) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            last_out = out_hs & (out_cnt == reg2dp_elem_num);
            if (last_out) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Stage occupancy: a stage fills on its load strobe and empties when its
   // contents move on without being replaced.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         p1_vld <= 1'b0;
         p2_vld <= 1'b0;
      end else begin
         p1_vld <= load_din_d | (p1_vld & ~load_din_2d);
         p2_vld <= load_din_2d | (p2_vld & ~sum_out_rdy);
      end
   end

   // Element counters; the final event is detected before incrementing so an
   // all-ones element count never wraps the counter.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         in_cnt  <= '0;
         out_cnt <= '0;
      end else if (start) begin
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         if (load_din_d && !last_in) begin
            in_cnt <= in_cnt + CNT_W'(1);
         end
         if (out_hs && !last_out && (state != IDLE)) begin
            out_cnt <= out_cnt + CNT_W'(1);
         end
      end
   end

   // Completion pulse follows the cycle of the last output handshake.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         dp2reg_done <= 1'b0;
      end else begin
         dp2reg_done <= last_out;
      end
   end

   // Window length is latched at op start so later register writes are ignored.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         len_sel <= 2'd0;
         len5    <= 1'b0;
         len7    <= 1'b0;
         len9    <= 1'b0;
      end else if (start) begin
         len_sel <= reg2dp_normalz_len;
         len5    <= (reg2dp_normalz_len == 2'd1);
         len7    <= (reg2dp_normalz_len == 2'd2);
         len9    <= (reg2dp_normalz_len == 2'd3);
      end
   end

`ifdef INT_SUM_CTRL_PERF_EN
   // Saturating count of cycles where a finished sum waits on the consumer.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         dp2reg_stall_cnt <= '0;
      end else if (start) begin
         dp2reg_stall_cnt <= '0;
      end else if (sum_out_vld && !sum_out_rdy && !(&dp2reg_stall_cnt)) begin
         dp2reg_stall_cnt <= dp2reg_stall_cnt + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_int_sum_ctrl.sv
// tb_int_sum_ctrl: randomized and directed bench for int_sum_ctrl. A queue of
// accept times models the two-deep sum pipeline; every output is compared
// against that model each cycle. Honors INT_SUM_CTRL_PERF_EN like the design.
module tb_int_sum_ctrl;

   logic        clk;
   logic        rstn;
   logic        opEn;
   logic [1:0]  normLen;
   logic [15:0] elemNum;
   logic        sqInVld;
   logic        sqInRdy;
   logic        sumOutVld;
   logic        sumOutRdy;
   logic        loadD;
   logic        load2D;
   logic        len5;
   logic        len7;
   logic        len9;
   logic [1:0]  lenSel;
   logic        opBusy;
   logic        done;
`ifdef INT_SUM_CTRL_PERF_EN
   logic [31:0] stallCnt;
`endif

   int checkCount = 0;
   int failCount  = 0;

   // Behavioural model state.
   int          cyc = 0;
   int          mQ[$];
   bit          mBusy = 0;
   bit          mDone = 0;
   int          mN = 0;
   int          mAcc = 0;
   int          mOuts = 0;
   logic [1:0]  mLen = 0;
   logic [31:0] mStall = 0;
   int          obsOuts = 0;
   int          doneSeen = 0;

   int_sum_ctrl #(.CNT_W(16), .PERF_W(32)) dut (
      .nvdla_core_clk     (clk),
      .nvdla_core_rstn    (rstn),
      .reg2dp_op_en       (opEn),
      .reg2dp_normalz_len (normLen),
      .reg2dp_elem_num    (elemNum),
      .sq_in_vld          (sqInVld),
      .sq_in_rdy          (sqInRdy),
      .sum_out_vld        (sumOutVld),
      .sum_out_rdy        (sumOutRdy),
      .load_din_d         (loadD),
      .load_din_2d        (load2D),
      .len5               (len5),
      .len7               (len7),
      .len9               (len9),
      .len_sel            (lenSel),
      .op_busy            (opBusy),
      .dp2reg_done        (done)
`ifdef INT_SUM_CTRL_PERF_EN
      ,
      .dp2reg_stall_cnt   (stallCnt)
`endif
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic modelReset();
      mQ.delete();
      mBusy  = 0;
      mDone  = 0;
      mAcc   = 0;
      mOuts  = 0;
      mLen   = 0;
      mStall = 0;
   endtask

   // One clock cycle: compare at the falling edge, advance the model after the rising edge.
   task automatic applyStimulus();
      bit expRdy, expVld, expLd, expLd2, hs, lastOut;
      int nItems;
      @(negedge clk);
      nItems  = mQ.size();
      expVld  = (nItems > 0) && (mQ[0] + 2 <= cyc);
      expRdy  = mBusy && (mAcc < mN) && ((nItems < 2) || sumOutRdy);
      expLd   = sqInVld && expRdy;
      expLd2  = ((nItems - int'(expVld)) > 0) && (!expVld || sumOutRdy);
      hs      = expVld && sumOutRdy;
      lastOut = hs && (mOuts == mN - 1);
      checkOutput("sq_in_rdy", 32'(sqInRdy), 32'(expRdy));
      checkOutput("sum_out_vld", 32'(sumOutVld), 32'(expVld));
      checkOutput("load_din_d", 32'(loadD), 32'(expLd));
      checkOutput("load_din_2d", 32'(load2D), 32'(expLd2));
      checkOutput("op_busy", 32'(opBusy), 32'(mBusy));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("len_sel", 32'(lenSel), 32'(mLen));
      checkOutput("len5", 32'(len5), 32'(mLen == 2'd1));
      checkOutput("len7", 32'(len7), 32'(mLen == 2'd2));
      checkOutput("len9", 32'(len9), 32'(mLen == 2'd3));
`ifdef INT_SUM_CTRL_PERF_EN
      checkOutput("stall_cnt", stallCnt, mStall);
`endif
      if (sumOutVld && sumOutRdy) obsOuts++;
      if (done) doneSeen++;
      @(posedge clk);
      #1;
      if (expVld && !sumOutRdy && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
      mDone = mBusy && lastOut;
      if (!mBusy && opEn) begin
         mBusy  = 1;
         mAcc   = 0;
         mOuts  = 0;
         mN     = int'(elemNum) + 1;
         mLen   = normLen;
         mStall = 0;
         mQ.delete();
      end else if (mBusy) begin
         if (expLd) begin
            mQ.push_back(cyc);
            mAcc++;
         end
         if (hs) begin
            void'(mQ.pop_front());
            mOuts++;
         end
         if (lastOut) mBusy = 0;
      end
      cyc++;
   endtask

   // Run one operation. mode 0: continuous flow; 1: consumer stalls on
   // op-relative cycles 4-6; 2: 50% random valid/ready; 3: continuous flow with
   // a length register write mid-run. holdEn keeps op_en high through done.
   task automatic runOp(input int lenV, input int elemV, input int mode, input bit holdEn);
      int t;
      int expOps;
      t        = 0;
      obsOuts  = 0;
      doneSeen = 0;
      expOps   = holdEn ? 2 : 1;
      normLen  = 2'(lenV);
      elemNum  = 16'(elemV);
      opEn     = 1'b1;
      do begin
         case (mode)
            1: begin
               sqInVld   = 1'b1;
               sumOutRdy = !(t >= 4 && t <= 6);
            end
            2: begin
               sqInVld   = 1'($urandom % 2);
               sumOutRdy = 1'($urandom % 2);
            end
            default: begin
               sqInVld   = 1'b1;
               sumOutRdy = 1'b1;
            end
         endcase
         if (mode == 3 && t == 5) normLen = 2'd0;
         applyStimulus();
         opEn = holdEn && (doneSeen == 0);
         t++;
      end while ((mBusy || mDone) && t < 5000);
      if (t >= 5000) checkOutput("timeout", 32'd1, 32'd0);
      checkOutput("out_count", 32'(obsOuts), 32'(expOps * (elemV + 1)));
      checkOutput("done_count", 32'(doneSeen), 32'(expOps));
      sqInVld   = 1'b0;
      sumOutRdy = 1'b0;
      applyStimulus();
   endtask

   initial begin
      rstn      = 1'b0;
      opEn      = 1'b0;
      normLen   = 2'd0;
      elemNum   = 16'd0;
      sqInVld   = 1'b0;
      sumOutRdy = 1'b0;
      modelReset();
      #23;
      checkOutput("rst_busy", 32'(opBusy), 32'd0);
      checkOutput("rst_len_sel", 32'(lenSel), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus();

      // Continuous flow, window 5.
      runOp(1, 3, 0, 1'b0);
      checkOutput("t1_len5", 32'(len5), 32'd1);
      checkOutput("t1_len_sel", 32'(lenSel), 32'd1);

      // Consumer stall with window 9.
      runOp(3, 7, 1, 1'b0);
`ifdef INT_SUM_CTRL_PERF_EN
      checkOutput("t2_stall3", stallCnt, 32'd3);
`endif

      // Single element, window 3.
      runOp(0, 0, 0, 1'b0);
      checkOutput("t3_len_sel", 32'(lenSel), 32'd0);

      // Length register rewritten mid-run must not disturb the latched decode.
      runOp(3, 10, 3, 1'b0);
      checkOutput("t4_len9", 32'(len9), 32'd1);

      // op_en held through done: a second op follows.
      runOp(2, 4, 0, 1'b1);

      // Reset while both stages are full.
      normLen   = 2'd2;
      elemNum   = 16'd20;
      opEn      = 1'b1;
      sqInVld   = 1'b1;
      sumOutRdy = 1'b0;
      applyStimulus();
      opEn = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus();
      rstn = 1'b0;
      #1;
      modelReset();
      checkOutput("mr_rdy", 32'(sqInRdy), 32'd0);
      checkOutput("mr_vld", 32'(sumOutVld), 32'd0);
      checkOutput("mr_ld", 32'(loadD), 32'd0);
      checkOutput("mr_ld2", 32'(load2D), 32'd0);
      checkOutput("mr_busy", 32'(opBusy), 32'd0);
      checkOutput("mr_len7", 32'(len7), 32'd0);
      checkOutput("mr_done", 32'(done), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus();
      runOp(1, 5, 0, 1'b0);

      // Random flow over 256 elements.
      runOp(int'($urandom_range(0, 3)), 255, 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/int_sum_ctrl.md
Name: int_sum_ctrl

Overview:
- Sequencer for the CDP/LRN local-window sum-of-squares datapath: converts a valid/ready stream of squared samples into the two load strobes (stage-1 pair sums, stage-2 window sum) and window-length decodes that the sum block consumes.
- Tracks occupancy of the two-stage sum pipeline, applies downstream backpressure, counts elements per operation and pulses done when the last sum leaves.
- Sits between the square/LUT front end and the normalization multiplier.

Parameters:
- CNT_W, 16, width of element-count register and counters.
- PERF_W, 32, width of the optional stall counter.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- reg2dp_op_en  in  1  operation start request, level, sampled in IDLE only.
- reg2dp_normalz_len  in  2  window: 0=3, 1=5, 2=7, 3=9.
- reg2dp_elem_num  in  CNT_W  element count minus one.
- sq_in_vld  in  1  squared-sample vector valid.
- sq_in_rdy  out  1  accept.
- sum_out_vld  out  1  window sum valid at sum block output.
- sum_out_rdy  in  1  downstream accept.
- load_din_d  out  1  stage-1 capture strobe.
- load_din_2d  out  1  stage-2 capture strobe.
- len5  out  1  latched decode, window 5.
- len7  out  1  latched decode, window 7.
- len9  out  1  latched decode, window 9.
- len_sel  out  2  latched window length for the sum output mux.
- op_busy  out  1  high outside IDLE.
- dp2reg_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; p1_vld, p2_vld, counters, len_sel all 0.
- Length decode: on the IDLE->RUN transition, len_sel <= reg2dp_normalz_len. len5 = (len_sel==1), len7 = (len_sel==2), len9 = (len_sel==3); all registered. Changes to reg2dp_normalz_len outside IDLE are ignored.
- States:
  - IDLE: sq_in_rdy=0. If reg2dp_op_en=1, go to RUN and clear in_cnt and out_cnt.
  - RUN: accept inputs. When the accepted input count reaches elem_num+1, go to DRAIN in the same cycle as the last accept.
  - DRAIN: sq_in_rdy=0. When the last output handshake occurs (out_cnt==elem_num with sum_out_vld & sum_out_rdy), dp2reg_done=1 for the next cycle, then go to IDLE.
- Pipeline control, combinational from registered state:
  - load_din_2d = p1_vld & (~p2_vld | sum_out_rdy).
  - sq_in_rdy = (state==RUN) & (~p1_vld | load_din_2d).
  - load_din_d = sq_in_vld & sq_in_rdy.
  - sum_out_vld = p2_vld.
- Valid registers:
  - p1_vld <= load_din_d | (p1_vld & ~load_din_2d).
  - p2_vld <= load_din_2d | (p2_vld & ~sum_out_rdy).
- Throughput and latency: full rate, one sample per cycle with no bubbles under continuous ready. Latency is 2 cycles from input accept to sum_out_vld.
- Backpressure: sum_out_rdy=0 with both stages full -> sq_in_rdy=0 the same cycle. Data is held because neither load strobe fires.
- Counters: in_cnt increments on load_din_d; out_cnt increments on the output handshake. Both have width CNT_W. elem_num=all-ones is legal; counters compare before incrementing, so there is no wrap.
- reg2dp_elem_num is sampled live and must be static while op_busy=1.
- Simultaneous events: the last input accept and an earlier output handshake in the same cycle are both counted. The done pulse and reg2dp_op_en=1 in the same cycle: the new op starts one cycle after returning to IDLE.
- Reset mid-operation clears all state. In-flight sums are discarded and no done pulse is produced.

Optional Feature:
- Macro: INT_SUM_CTRL_PERF_EN.
- Defined: adds output dp2reg_stall_cnt [PERF_W-1:0].
  - Increments each cycle with sum_out_vld & ~sum_out_rdy.
  - Saturates at all-ones.
  - Clears on the IDLE->RUN transition and at reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- len=1, elem_num=3, sq_in_vld and sum_out_rdy held 1 -> load_din_d high on cycles 1-4; load_din_2d on cycles 2-5; sum_out_vld on cycles 3-6; dp2reg_done on cycle 7; len5=1, len7=len9=0, len_sel=1.
- len=3, elem_num=7, sum_out_rdy low for cycles 4-6 -> sq_in_rdy drops while both stages are full; no strobe fires during the stall; exactly 8 output handshakes; done once; stall_cnt=3 when PERF_EN is defined.
- elem_num=0, len=0 -> a single input is accepted; DRAIN is entered immediately; one output; done; len5/len7/len9 all 0.
- reg2dp_normalz_len changed 3->0 mid-RUN -> len9 stays 1 and len_sel stays 3 until the next op start.
- Reset asserted with p1_vld=p2_vld=1 in RUN -> all outputs are 0 immediately; no done pulse; a new op_en starts cleanly with counts of 0.
- Random sq_in_vld/sum_out_rdy at 50% over elem_num=255 -> 256 outputs in order, no drops or duplicates, done exactly once.
